biquad8_coeff_sequencer: RTL and testbench
==========================================

BIQUAD8_COEFF_SEQUENCER -- requirements
Module: biquad8_coeff_sequencer

Interface
REQ-001 Parameter NCOEFF, 2, number of coefficients per load (the DSP B-cascade depth).
REQ-002 Parameter CWIDTH, 18, coefficient width; equals the DSP B port width.
REQ-003 Parameter ADRBITS, 1, shadow address width; 2**ADRBITS >= NCOEFF.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; the port names SHALL be clk and rst.
REQ-005 clk  input  1  sole clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 cfg_adr_i  input  ADRBITS  shadow register address.
REQ-008 cfg_dat_i  input  CWIDTH  shadow write data.
REQ-009 cfg_wr_i  input  1  shadow write strobe, one cycle per write.
REQ-010 cfg_commit_i  input  1  request to load the shadow set into the filter.
REQ-011 busy_o  output  1  high while a load sequence is running.
REQ-012 done_o  output  1  one-cycle pulse marking the end of a sequence.
REQ-013 wr_err_o  output  1  one-cycle pulse when a write is dropped.
REQ-014 coeff_dat_o  output  CWIDTH  coefficient to the filter; drives coeff_dat_i of the filter.
REQ-015 coeff_wr_o  output  1  B1 shift strobe to the filter's coeff_wr_i.
REQ-016 coeff_update_o  output  1  B2 load strobe to the filter's coeff_update_i.

Function
REQ-017 The block SHALL hold NCOEFF shadow registers of CWIDTH bits, written on cfg_wr_i when cfg_adr_i < NCOEFF.
REQ-018 A write with cfg_adr_i >= NCOEFF SHALL be ignored without any error indication.
REQ-019 The FSM SHALL have the states IDLE, WR, HOLD and UPD, with a down-counter idx.
REQ-020 In IDLE, cfg_commit_i SHALL cause the transition to WR with idx = NCOEFF-1 on the next edge.
REQ-021 WR SHALL drive coeff_wr_o=1 and coeff_dat_o=shadow[idx], then go to HOLD.
REQ-022 HOLD SHALL drive coeff_wr_o=0 and keep coeff_dat_o unchanged, because the filter registers its B clock-enable one cycle after the data. HOLD SHALL then:
- go to WR with idx-1 if idx > 0;
- otherwise go to UPD.
REQ-023 UPD SHALL drive coeff_update_o=1 and done_o=1 for exactly one cycle, then go to IDLE.
REQ-024 Shadow entries SHALL be emitted from highest to lowest index, so index 0 lands in the low DSP and index NCOEFF-1 in the high DSP.
REQ-025 busy_o SHALL be 1 in the WR, HOLD and UPD states; each sequence SHALL occupy exactly 2*NCOEFF+1 cycles.
REQ-026 A commit accepted at edge t SHALL produce coeff_wr_o at cycles t+1, t+3, ... and coeff_update_o at cycle t+2*NCOEFF+1.
REQ-027 A write and a commit in the same IDLE cycle SHALL both take effect; the sequence SHALL emit the newly written value.
REQ-028 cfg_wr_i while busy_o=1 SHALL be dropped, leaving the shadow unchanged, and wr_err_o SHALL pulse in the following cycle.
REQ-029 cfg_commit_i while busy_o=1 SHALL set a single pending flag. Repeated commits SHALL NOT queue more than one.
REQ-030 With pending set, UPD SHALL go directly to WR with idx = NCOEFF-1 and clear pending; done_o SHALL still pulse in that UPD cycle.
REQ-031 coeff_dat_o SHALL be 0 in IDLE and UPD.
REQ-032 A commit with no intervening writes SHALL still run a full sequence.

Reset
REQ-033 rst SHALL return the block to IDLE and clear pending, idx and all shadow registers to 0.
REQ-034 During reset all outputs SHALL be 0, with effect from the next edge.
REQ-035 Reset mid-sequence SHALL abort without ever asserting coeff_update_o, so the filter keeps its previously active coefficients in B2.
REQ-036 Inputs sampled while rst=1 SHALL be ignored.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, the default CWIDTH of 18 and the default NCOEFF of 2.
REQ-038 The block SHALL be a single module with no sub-modules; the shadow registers, FSM and counter are inline.

Verification
REQ-039 Write 0x00123 to address 0 and 0x3FFFF to address 1, then commit at edge 0 -> the bench observes:
- coeff_wr_o at cycles 1 and 3;
- coeff_dat_o = 0x3FFFF in cycles 1-2 and 0x00123 in cycles 3-4;
- coeff_update_o and done_o at cycle 5;
- busy_o high in cycles 1-5.
REQ-040 Write 0x00055 to address 1 and commit in the same cycle -> the first emitted value is 0x00055.
REQ-041 Write during busy -> the shadow is unchanged, wr_err_o pulses once, and a later commit emits the old value.
REQ-042 Three commits during one sequence -> exactly two complete sequences run, with back-to-back UPD->WR and two done_o pulses.
REQ-043 Assert rst at cycle 3 of a sequence -> all outputs are 0 from the next cycle, coeff_update_o never asserts, and the shadow reads 0 on the next commit.
REQ-044 Write to address 2 with ADRBITS=2 and NCOEFF=2 -> ignored, wr_err_o stays 0, and the emitted values are unchanged.

Source files
------------

// File: rtl/biquad8_coeff_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// biquad8_coeff_sequencer_pkg
// Shared definitions for the biquad coefficient sequencer: the load-sequence
// FSM state encoding and the default coefficient geometry (one 18-bit DSP B
// port per coefficient, two cascaded DSPs).
// -----------------------------------------------------------------------------
package biquad8_coeff_sequencer_pkg;

  localparam int CWIDTH_DEFAULT = 18;
  localparam int NCOEFF_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_HOLD = 2'd2,
    ST_UPD  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/biquad8_coeff_sequencer.sv
// -----------------------------------------------------------------------------
// biquad8_coeff_sequencer
// Holds a shadow set of NCOEFF filter coefficients and, on commit, shifts them
// into the filter's B1 cascade (highest index first, one WR/HOLD cycle pair per
// coefficient), then pulses the B2 load strobe. A commit arriving while a load
// is running is remembered as a single pending request.
//
// Ports
//   clk            sole clock
//   rst            synchronous, active-high reset
//   cfg_adr_i      shadow register address (ADRBITS)
//   cfg_dat_i      shadow write data (CWIDTH)
//   cfg_wr_i       shadow write strobe, one cycle per write
//   cfg_commit_i   request to load the shadow set into the filter
//   busy_o         high while a load sequence is running
//   done_o         one-cycle pulse at the end of a sequence
//   wr_err_o       one-cycle pulse when a write was dropped because busy
//   coeff_dat_o    coefficient data to the filter (CWIDTH)
//   coeff_wr_o     B1 shift strobe to the filter
//   coeff_update_o B2 load strobe to the filter
// -----------------------------------------------------------------------------
module biquad8_coeff_sequencer
  import biquad8_coeff_sequencer_pkg::*;
#(
  parameter int NCOEFF  = NCOEFF_DEFAULT,
  parameter int CWIDTH  = CWIDTH_DEFAULT,
  parameter int ADRBITS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADRBITS-1:0] cfg_adr_i,
  input  logic [CWIDTH-1:0]  cfg_dat_i,
  input  logic               cfg_wr_i,
  input  logic               cfg_commit_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               wr_err_o,
  output logic [CWIDTH-1:0]  coeff_dat_o,
  output logic               coeff_wr_o,
  output logic               coeff_update_o
);

  localparam logic [ADRBITS-1:0] IDX_TOP = ADRBITS'(NCOEFF - 1);

  logic [CWIDTH-1:0]  r_shadow [NCOEFF];
  seq_state_e         r_state;
  seq_state_e         w_state_nxt;
  logic [ADRBITS-1:0] r_idx;
  logic [ADRBITS-1:0] w_idx_nxt;
  logic               r_pending;
  logic               w_pending_nxt;
  logic               r_wr_err;
  logic               w_busy;
  logic               w_adr_ok;
  logic [CWIDTH-1:0]  w_shadow_sel;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_adr_ok = (int'(cfg_adr_i) < NCOEFF);
  assign busy_o   = w_busy;
  assign wr_err_o = r_wr_err;

  // Shadow set. Writes are only accepted in IDLE so the values being shifted
  // out stay stable for the whole sequence; out-of-range addresses fall through
  // the decode silently.
  // NOTE: the shadow array is explicitly cleared on reset because a reset must
  // leave an all-zero coefficient set behind for the next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCOEFF; k++) r_shadow[k] <= '0;
    end else if (cfg_wr_i && !w_busy) begin
      for (int k = 0; k < NCOEFF; k++) begin
        if (cfg_adr_i == ADRBITS'(k)) r_shadow[k] <= cfg_dat_i;
      end
    end
  end

  // A dropped write is flagged one cycle later; out-of-range writes never are.
  always_ff @(posedge clk) begin
    if (rst) r_wr_err <= 1'b0;
    else     r_wr_err <= cfg_wr_i && w_busy && w_adr_ok;
  end

  // Read mux for the coefficient currently addressed by the down-counter.
  always_comb begin
    w_shadow_sel = '0;
    for (int k = 0; k < NCOEFF; k++) begin
      if (r_idx == ADRBITS'(k)) w_shadow_sel = r_shadow[k];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_pending_nxt  = r_pending;
    coeff_dat_o    = '0;
    coeff_wr_o     = 1'b0;
    coeff_update_o = 1'b0;
    done_o         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (cfg_commit_i) begin
          w_state_nxt = ST_WR;
          w_idx_nxt   = IDX_TOP;
        end
      end
      ST_WR: begin
        coeff_wr_o  = 1'b1;
        coeff_dat_o = w_shadow_sel;
        if (cfg_commit_i) w_pending_nxt = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // The filter registers its B clock-enable a cycle after the data, so
        // the data must stay on the bus for one more cycle.
        coeff_dat_o = w_shadow_sel;
        if (cfg_commit_i) w_pending_nxt = 1'b1;
        if (r_idx != '0) begin
          w_state_nxt = ST_WR;
          w_idx_nxt   = r_idx - ADRBITS'(1);
        end else begin
          w_state_nxt = ST_UPD;
        end
      end
      ST_UPD: begin
        coeff_update_o = 1'b1;
        done_o         = 1'b1;
        // A commit seen here is folded into the pending request rather than
        // being lost on the way back through IDLE.
        if (r_pending || cfg_commit_i) begin
          w_state_nxt   = ST_WR;
          w_idx_nxt     = IDX_TOP;
          w_pending_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_biquad8_coeff_sequencer.sv
// -----------------------------------------------------------------------------
// tb_biquad8_coeff_sequencer
// Directed bench for biquad8_coeff_sequencer (NCOEFF=2, CWIDTH=18, ADRBITS=2
// so that an out-of-range address exists). Each scenario is a table of
// per-cycle stimulus and the hand-computed outputs for the following cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_biquad8_coeff_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_adr_i;
  logic [17:0] cfg_dat_i;
  logic        cfg_wr_i;
  logic        cfg_commit_i;
  logic        busy_o;
  logic        done_o;
  logic        wr_err_o;
  logic [17:0] coeff_dat_o;
  logic        coeff_wr_o;
  logic        coeff_update_o;

  int n_cmp = 0;
  int n_bad = 0;

  biquad8_coeff_sequencer #(
    .NCOEFF (2),
    .CWIDTH (18),
    .ADRBITS(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_adr_i     (cfg_adr_i),
    .cfg_dat_i     (cfg_dat_i),
    .cfg_wr_i      (cfg_wr_i),
    .cfg_commit_i  (cfg_commit_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .wr_err_o      (wr_err_o),
    .coeff_dat_o   (coeff_dat_o),
    .coeff_wr_o    (coeff_wr_o),
    .coeff_update_o(coeff_update_o)
  );

  always #5 clk = ~clk;

  // stimulus word: {rst, wr, commit, adr[1:0], dat[17:0]}
  function automatic logic [22:0] mk_stim(input logic r, input logic w, input logic c,
                                          input logic [1:0] a, input logic [17:0] d);
    return {r, w, c, a, d};
  endfunction

  // expected word: {busy, coeff_wr, coeff_update, done, wr_err, coeff_dat[17:0]}
  function automatic logic [22:0] mk_exp(input logic b, input logic w, input logic u,
                                         input logic dn, input logic er, input logic [17:0] d);
    return {b, w, u, dn, er, d};
  endfunction

  function automatic logic [22:0] observed();
    return {busy_o, coeff_wr_o, coeff_update_o, done_o, wr_err_o, coeff_dat_o};
  endfunction

  // Drive one cycle of stimulus, let the edge happen, settle just after it.
  task automatic apply(input logic [22:0] v);
    rst          = v[22];
    cfg_wr_i     = v[21];
    cfg_commit_i = v[20];
    cfg_adr_i    = v[19:18];
    cfg_dat_i    = v[17:0];
    @(posedge clk);
    #1;
  endtask

  localparam logic [22:0] IDLE_IN  = 23'h0;
  localparam logic [22:0] IDLE_OUT = 23'h0;

  task automatic test_reset();
    logic [22:0] obs;
    apply(mk_stim(1, 1, 1, 2'd1, 18'h3FFFF));
    obs = observed();
    n_cmp++;
    if (obs !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL reset_first: got flags=%b dat=%h want flags=00000 dat=00000", obs[22:18], obs[17:0]);
    end
    apply(mk_stim(1, 0, 1, 2'd0, 18'h0));
    obs = observed();
    n_cmp++;
    if (obs !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL reset_held: got flags=%b dat=%h want flags=00000 dat=00000", obs[22:18], obs[17:0]);
    end
    apply(IDLE_IN);
    obs = observed();
    n_cmp++;
    if (obs !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL reset_release: got flags=%b dat=%h want flags=00000 dat=00000", obs[22:18], obs[17:0]);
    end
  endtask

  // Shadow {0:0x00123, 1:0x3FFFF}; commit at edge 0.
  task automatic test_basic_load();
    logic [22:0] stim[$];
    logic [22:0] exp[$];
    logic [22:0] obs;
    apply(mk_stim(0, 1, 0, 2'd0, 18'h00123));
    apply(mk_stim(0, 1, 0, 2'd1, 18'h3FFFF));
    obs = observed();
    n_cmp++;
    if (obs !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL basic_preload: got flags=%b dat=%h want idle", obs[22:18], obs[17:0]);
    end
    stim = '{mk_stim(0, 0, 1, 2'd0, 18'h0), IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN};
    exp  = '{mk_exp(1, 1, 0, 0, 0, 18'h3FFFF), mk_exp(1, 0, 0, 0, 0, 18'h3FFFF),
             mk_exp(1, 1, 0, 0, 0, 18'h00123), mk_exp(1, 0, 0, 0, 0, 18'h00123),
             mk_exp(1, 0, 1, 1, 0, 18'h0), IDLE_OUT};
    for (int c = 0; c < stim.size(); c++) begin
      apply(stim[c]);
      obs = observed();
      n_cmp++;
      if (obs !== exp[c]) begin
        n_bad++;
        $display("FAIL basic_load cycle %0d: got flags=%b dat=%h want flags=%b dat=%h",
                 c + 1, obs[22:18], obs[17:0], exp[c][22:18], exp[c][17:0]);
      end
    end
  endtask

  // Write 0x00055 to address 1 in the same cycle as the commit.
  task automatic test_write_with_commit();
    logic [22:0] stim[$];
    logic [22:0] exp[$];
    logic [22:0] obs;
    stim = '{mk_stim(0, 1, 1, 2'd1, 18'h00055), IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN};
    exp  = '{mk_exp(1, 1, 0, 0, 0, 18'h00055), mk_exp(1, 0, 0, 0, 0, 18'h00055),
             mk_exp(1, 1, 0, 0, 0, 18'h00123), mk_exp(1, 0, 0, 0, 0, 18'h00123),
             mk_exp(1, 0, 1, 1, 0, 18'h0), IDLE_OUT};
    for (int c = 0; c < stim.size(); c++) begin
      apply(stim[c]);
      obs = observed();
      n_cmp++;
      if (obs !== exp[c]) begin
        n_bad++;
        $display("FAIL write_with_commit cycle %0d: got flags=%b dat=%h want flags=%b dat=%h",
                 c + 1, obs[22:18], obs[17:0], exp[c][22:18], exp[c][17:0]);
      end
    end
  endtask

  // Write during busy is dropped and flagged; the next commit emits old data.
  task automatic test_write_busy();
    logic [22:0] stim[$];
    logic [22:0] exp[$];
    logic [22:0] obs;
    stim = '{mk_stim(0, 0, 1, 2'd0, 18'h0), mk_stim(0, 1, 0, 2'd1, 18'h1ABCD),
             IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN,
             mk_stim(0, 0, 1, 2'd0, 18'h0), IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN};
    exp  = '{mk_exp(1, 1, 0, 0, 0, 18'h00055), mk_exp(1, 0, 0, 0, 1, 18'h00055),
             mk_exp(1, 1, 0, 0, 0, 18'h00123), mk_exp(1, 0, 0, 0, 0, 18'h00123),
             mk_exp(1, 0, 1, 1, 0, 18'h0), IDLE_OUT,
             mk_exp(1, 1, 0, 0, 0, 18'h00055), mk_exp(1, 0, 0, 0, 0, 18'h00055),
             mk_exp(1, 1, 0, 0, 0, 18'h00123), mk_exp(1, 0, 0, 0, 0, 18'h00123),
             mk_exp(1, 0, 1, 1, 0, 18'h0), IDLE_OUT};
    for (int c = 0; c < stim.size(); c++) begin
      apply(stim[c]);
      obs = observed();
      n_cmp++;
      if (obs !== exp[c]) begin
        n_bad++;
        $display("FAIL write_busy cycle %0d: got flags=%b dat=%h want flags=%b dat=%h",
                 c + 1, obs[22:18], obs[17:0], exp[c][22:18], exp[c][17:0]);
      end
    end
  endtask

  // Initial commit plus three more during the sequence: exactly two sequences.
  task automatic test_back_to_back();
    logic [22:0] stim[$];
    logic [22:0] exp[$];
    logic [22:0] obs;
    int          n_done = 0;
    stim = '{mk_stim(0, 0, 1, 2'd0, 18'h0), mk_stim(0, 0, 1, 2'd0, 18'h0),
             mk_stim(0, 0, 1, 2'd0, 18'h0), mk_stim(0, 0, 1, 2'd0, 18'h0),
             IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN};
    exp  = '{mk_exp(1, 1, 0, 0, 0, 18'h00055), mk_exp(1, 0, 0, 0, 0, 18'h00055),
             mk_exp(1, 1, 0, 0, 0, 18'h00123), mk_exp(1, 0, 0, 0, 0, 18'h00123),
             mk_exp(1, 0, 1, 1, 0, 18'h0),
             mk_exp(1, 1, 0, 0, 0, 18'h00055), mk_exp(1, 0, 0, 0, 0, 18'h00055),
             mk_exp(1, 1, 0, 0, 0, 18'h00123), mk_exp(1, 0, 0, 0, 0, 18'h00123),
             mk_exp(1, 0, 1, 1, 0, 18'h0), IDLE_OUT};
    for (int c = 0; c < stim.size(); c++) begin
      apply(stim[c]);
      obs = observed();
      if (done_o) n_done++;
      n_cmp++;
      if (obs !== exp[c]) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: got flags=%b dat=%h want flags=%b dat=%h",
                 c + 1, obs[22:18], obs[17:0], exp[c][22:18], exp[c][17:0]);
      end
    end
    n_cmp++;
    if (n_done !== 2) begin
      n_bad++;
      $display("FAIL back_to_back_done_count: got %0d want 2", n_done);
    end
  endtask

  // Reset in cycle 3 aborts without update; writes/commits under reset ignored;
  // the next commit emits the cleared (zero) shadow.
  task automatic test_reset_mid_sequence();
    logic [22:0] stim[$];
    logic [22:0] exp[$];
    logic [22:0] obs;
    stim = '{mk_stim(0, 0, 1, 2'd0, 18'h0), IDLE_IN, IDLE_IN,
             mk_stim(1, 0, 0, 2'd0, 18'h0), mk_stim(1, 1, 1, 2'd1, 18'h2AAAA),
             IDLE_IN, mk_stim(0, 0, 1, 2'd0, 18'h0),
             IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN};
    exp  = '{mk_exp(1, 1, 0, 0, 0, 18'h00055), mk_exp(1, 0, 0, 0, 0, 18'h00055),
             mk_exp(1, 1, 0, 0, 0, 18'h00123), IDLE_OUT, IDLE_OUT, IDLE_OUT,
             mk_exp(1, 1, 0, 0, 0, 18'h0), mk_exp(1, 0, 0, 0, 0, 18'h0),
             mk_exp(1, 1, 0, 0, 0, 18'h0), mk_exp(1, 0, 0, 0, 0, 18'h0),
             mk_exp(1, 0, 1, 1, 0, 18'h0), IDLE_OUT};
    for (int c = 0; c < stim.size(); c++) begin
      apply(stim[c]);
      obs = observed();
      n_cmp++;
      if (obs !== exp[c]) begin
        n_bad++;
        $display("FAIL reset_mid_sequence cycle %0d: got flags=%b dat=%h want flags=%b dat=%h",
                 c + 1, obs[22:18], obs[17:0], exp[c][22:18], exp[c][17:0]);
      end
    end
  endtask

  // Writes to addresses 2 and 3 are silently ignored.
  task automatic test_addr_out_of_range();
    logic [22:0] stim[$];
    logic [22:0] exp[$];
    logic [22:0] obs;
    stim = '{mk_stim(0, 1, 0, 2'd0, 18'h00AAA), mk_stim(0, 1, 0, 2'd1, 18'h00BBB),
             mk_stim(0, 1, 0, 2'd2, 18'h3FFFF), mk_stim(0, 1, 1, 2'd3, 18'h11111),
             IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN};
    exp  = '{IDLE_OUT, IDLE_OUT, IDLE_OUT,
             mk_exp(1, 1, 0, 0, 0, 18'h00BBB), mk_exp(1, 0, 0, 0, 0, 18'h00BBB),
             mk_exp(1, 1, 0, 0, 0, 18'h00AAA), mk_exp(1, 0, 0, 0, 0, 18'h00AAA),
             mk_exp(1, 0, 1, 1, 0, 18'h0), IDLE_OUT};
    for (int c = 0; c < stim.size(); c++) begin
      apply(stim[c]);
      obs = observed();
      n_cmp++;
      if (obs !== exp[c]) begin
        n_bad++;
        $display("FAIL addr_out_of_range cycle %0d: got flags=%b dat=%h want flags=%b dat=%h",
                 c + 1, obs[22:18], obs[17:0], exp[c][22:18], exp[c][17:0]);
      end
    end
  endtask

  // Commit with no intervening writes still runs a full sequence.
  task automatic test_repeat_commit();
    logic [22:0] stim[$];
    logic [22:0] exp[$];
    logic [22:0] obs;
    stim = '{mk_stim(0, 0, 1, 2'd0, 18'h0), IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN, IDLE_IN};
    exp  = '{mk_exp(1, 1, 0, 0, 0, 18'h00BBB), mk_exp(1, 0, 0, 0, 0, 18'h00BBB),
             mk_exp(1, 1, 0, 0, 0, 18'h00AAA), mk_exp(1, 0, 0, 0, 0, 18'h00AAA),
             mk_exp(1, 0, 1, 1, 0, 18'h0), IDLE_OUT};
    for (int c = 0; c < stim.size(); c++) begin
      apply(stim[c]);
      obs = observed();
      n_cmp++;
      if (obs !== exp[c]) begin
        n_bad++;
        $display("FAIL repeat_commit cycle %0d: got flags=%b dat=%h want flags=%b dat=%h",
                 c + 1, obs[22:18], obs[17:0], exp[c][22:18], exp[c][17:0]);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    cfg_wr_i     = 1'b0;
    cfg_commit_i = 1'b0;
    cfg_adr_i    = '0;
    cfg_dat_i    = '0;
    #1;
    test_reset();
    test_basic_load();
    test_write_with_commit();
    test_write_busy();
    test_back_to_back();
    test_reset_mid_sequence();
    test_addr_out_of_range();
    test_repeat_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
